bf16_dot_seq: RTL and testbench

- Sequencer that time-multiplexes one combinational BF16 FMA unit to compute a dot product `acc = sum(a_i * b_i)` over a programmed number of element pairs.
- Operand pairs arrive on a valid/ready stream and are consumed one per cycle.
- The controller owns the accumulator register and drives the FMA's A/B/C operands. It collects the FMA status flags as sticky bits and presents the final result on a valid/ready output.
- Sits between the operand-fetch logic and the shared FMA datapath.

---
 rtl/bf16_dot_seq.sv | 117 +++++++++++
 tb/tb_bf16_dot_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_dot_seq.sv
// Dot-product sequencer: streams operand pairs through one external combinational
// BF16 FMA, accumulating into acc and OR-ing the FMA status flags into sticky bits.
module bf16_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      fma_a,
  output logic [15:0]      fma_b,
  output logic [15:0]      fma_c,
  input  logic [15:0]      fma_result,
  input  logic [6:0]       fma_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic [6:0]       flags,
  output logic [LEN_W-1:0] elem_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [6:0] FLAG_ZERO = 7'b1000000;

  state_t           state_reg, state_next;
  logic [15:0]      acc_reg, acc_next;
  logic [6:0]       flags_reg, flags_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [LEN_W-1:0] rem_reg, rem_next;
  logic [6:0]       fma_flags_clean;

  // The FMA leaves some flag bits undriven; only a solid 1 may reach the sticky register.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_flag_clean
      assign fma_flags_clean[gi] = (fma_flags[gi] === 1'b1);
    end
  endgenerate

  assign fma_a     = in_a;
  assign fma_b     = in_b;
  assign fma_c     = acc_reg;
  assign result    = acc_reg;
  assign flags     = flags_reg;
  assign elem_cnt  = cnt_reg;
  assign busy      = (state_reg != S_IDLE);
  assign in_ready  = (state_reg == S_RUN);
  assign out_valid = (state_reg == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      acc_reg   <= 16'h0000;
      flags_reg <= '0;
      cnt_reg   <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      flags_reg <= flags_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    flags_next = flags_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          acc_next = 16'h0000;
          cnt_next = '0;
          rem_next = len;
          if (len == '0) begin
            flags_next = FLAG_ZERO;
            state_next = S_DONE;
          end else begin
            flags_next = '0;
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        // abort wins over a simultaneous accept
        if (abort) begin
          state_next = S_IDLE;
        end else if (in_valid) begin
          acc_next   = fma_result;
          flags_next = flags_reg | fma_flags_clean;
          cnt_next   = cnt_reg + LEN_W'(1);
          rem_next   = rem_reg - LEN_W'(1);
          if (rem_reg == LEN_W'(1)) state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (abort || out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bf16_dot_seq.sv
// Bench for bf16_dot_seq: a real-arithmetic BF16 FMA model closes the loop, and
// a scoreboard checks every delivered result against a fold over the issued pairs.
module tb_bf16_dot_seq;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a, in_b;
  logic [15:0]      fma_a, fma_b, fma_c;
  logic [15:0]      fma_result;
  logic [6:0]       fma_flags;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      result;
  logic [6:0]       flags;
  logic [LEN_W-1:0] elem_cnt;

  always #5 clk = ~clk;

  bf16_dot_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_result(fma_result), .fma_flags(fma_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .elem_cnt(elem_cnt)
  );

  typedef struct packed {
    logic [15:0]      res;
    logic [6:0]       fl;
    logic [LEN_W-1:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] pa[16];
  logic [15:0] pb[16];

  // ---------------- BF16 FMA reference (bench-owned) ----------------
  function automatic real bf2r(input logic [15:0] v);
    real m;
    int  e;
    e = int'(v[14:7]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(int'(v[6:0])) / 128.0;
    while (e > 127) begin m = m * 2.0; e--; end
    while (e < 127) begin m = m / 2.0; e++; end
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2bf(input real r, output logic uf, output logic ov);
    logic [63:0] d;
    logic [8:0]  mr;
    logic        rnd;
    int          eb;
    uf = 1'b0;
    ov = 1'b0;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 15'h0000};
    eb  = int'(d[62:52]) - 1023 + 127;
    rnd = d[44] && ((|d[43:0]) || d[45]);
    mr  = {2'b01, d[51:45]} + {8'd0, rnd};
    if (mr[8]) begin eb++; mr = mr >> 1; end
    if (eb >= 255) begin ov = 1'b1; return {d[63], 15'h7F80}; end
    if (eb <= 0) begin uf = 1'b1; return {d[63], 15'h0000}; end
    return {d[63], 8'(eb), mr[6:0]};
  endfunction

  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:7] == 8'hFF) && (v[6:0] != 7'd0);
  endfunction

  function automatic logic is_snan(input logic [15:0] v);
    return is_nan(v) && !v[6];
  endfunction

  // Stimulus keeps a and b finite; only the accumulator can become inf/NaN.
  function automatic logic [22:0] fma_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
    logic [15:0] res;
    logic [6:0]  fl;
    logic        uf, ov;
    fl = '0;
    uf = 1'b0;
    ov = 1'b0;
    if (is_nan(a) || is_nan(b) || is_nan(c)) begin
      res   = 16'h7FC0;
      fl[3] = 1'b1;
      fl[2] = is_snan(a) || is_snan(b) || is_snan(c);
    end else if (c[14:7] == 8'hFF) begin
      res = c;
    end else begin
      res = r2bf(bf2r(a) * bf2r(b) + bf2r(c), uf, ov);
    end
    fl[6] = (res[14:0] == 15'd0);
    fl[5] = uf;
    fl[4] = ov;
    fl[1] = (res == 16'h7F80);
    fl[0] = (res == 16'hFF80);
    return {res, fl};
  endfunction

  always_comb begin
    {fma_result, fma_flags} = fma_model(fma_a, fma_b, fma_c);
  end

  // Expected outcome of a complete operation: fold of the FMA over the pairs.
  function automatic exp_t ref_dot(input int n);
    exp_t        e;
    logic [22:0] t;
    e.res = 16'h0000;
    e.fl  = (n == 0) ? 7'b1000000 : 7'b0000000;
    e.cnt = LEN_W'(n);
    for (int i = 0; i < n; i++) begin
      t     = fma_model(pa[i], pb[i], e.res);
      e.res = t[22:7];
      e.fl  = e.fl | t[6:0];
    end
    return e;
  endfunction

  function automatic logic [15:0] rnd_op();
    int k;
    k = $urandom_range(0, 15);
    if (k == 0) return 16'h0000;
    if (k == 1) return {1'($urandom_range(0, 1)), 15'h7F7F};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 7'($urandom_range(0, 127))};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("flags", 32'(flags), 32'(e.fl));
        chk("elem_cnt", 32'(elem_cnt), 32'(e.cnt));
        $display("txn: result=%h flags=%b cnt=%0d (exp %h %b %0d)",
                 result, flags, elem_cnt, e.res, e.fl, e.cnt);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation of n_len pairs and feeds the first n_send of them.
  task automatic run_op(input int n_len, input int n_send, input int gap,
                        input bit chk_gap, input bit push);
    int g, k;
    if (push) exp_q.push_back(ref_dot(n_len));
    start = 1'b1;
    len   = LEN_W'(n_len);
    tick();
    start = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      in_valid = 1'b0;
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      repeat (g) begin
        @(negedge clk);
        if (chk_gap) begin
          chk("busy_gap", 32'(busy), 32'd1);
          chk("cnt_hold", 32'(elem_cnt), 32'(i));
        end
        tick();
      end
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input bit rand_ready);
    int k;
    k = 0;
    forever begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) break;
      k++;
      if (k > 100) begin
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
        break;
      end
      tick();
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic abort_pulse();
    abort    = 1'b1;
    in_valid = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000; out_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_elem_cnt", 32'(elem_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1*2 + 2*3 = 8, back-to-back pairs, consumer always ready
    pa[0] = 16'h3F80; pb[0] = 16'h4000; pa[1] = 16'h4000; pb[1] = 16'h4040;
    out_ready = 1'b1;
    run_op(2, 2, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("case1_result", 32'(result), 32'h4100);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("case1_idle", 32'(busy), 32'd0);
    tick();

    // same stream with 3-cycle gaps
    run_op(2, 2, 3, 1'b1, 1'b1);
    wait_result(1'b0);

    // overflow; consumer stalls while a stray start arrives
    pa[0] = 16'h7F7F; pb[0] = 16'h7F7F;
    run_op(1, 1, 0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      start = (c == 1);
      len   = LEN_W'(5);
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(result), 32'h7F80);
      chk("stall_flags", 32'(flags), 32'b0010010);
      tick();
    end
    start = 1'b1;
    len   = LEN_W'(3);
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("start_at_handshake_ignored", 32'(busy), 32'd0);
    tick();

    // zero-length operation
    run_op(0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("len0_out_valid", 32'(out_valid), 32'd1);
    tick();
    wait_result(1'b0);
    @(negedge clk);
    chk("len0_idle", 32'(busy), 32'd0);
    tick();

    // abort after 2 of 4 accepts, with a pair offered in the abort cycle
    pa[0] = 16'h3F80; pb[0] = 16'h4000; pa[1] = 16'h4000; pb[1] = 16'h4040;
    out_ready = 1'b1;
    run_op(4, 2, 0, 1'b0, 1'b0);
    abort_pulse();
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_cnt_kept", 32'(elem_cnt), 32'd2);
    repeat (3) tick();
    out_ready = 1'b0;
    pa[0] = 16'h3F80; pb[0] = 16'h3F80;
    run_op(1, 1, 0, 1'b0, 1'b1);
    wait_result(1'b0);

    // reset mid-run
    pa[0] = 16'h4000; pb[0] = 16'h4000;
    run_op(3, 1, 0, 1'b0, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", 32'(flags), 32'd0);
    chk("midrst_elem_cnt", 32'(elem_cnt), 32'd0);
    tick();

    // randomized operations, some aborted in RUN or DONE
    for (int op = 0; op < 40; op++) begin
      int n, mode;
      n = $urandom_range(1, 12);
      mode = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        pa[i] = rnd_op();
        pb[i] = rnd_op();
      end
      if (mode == 0) begin
        run_op(n, $urandom_range(0, n - 1), -1, 1'b0, 1'b0);
        abort_pulse();
        @(negedge clk);
        chk("rand_abort_run", 32'(busy), 32'd0);
        tick();
      end else if (mode == 1) begin
        run_op(n, n, -1, 1'b0, 1'b0);
        abort_pulse();
        @(negedge clk);
        chk("rand_abort_done", 32'(out_valid), 32'd0);
        tick();
      end else begin
        run_op(n, n, -1, 1'b0, 1'b1);
        wait_result(1'b1);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
